flash_read_ctrl: RTL and testbench

Parametrised read controller for the board's 16-bit parallel NOR flash. It sits between the MEM stage and the flash pins. It accepts one load request at a time over a valid/ready handshake. It issues the read-array command only when the flash is not already in array mode, and runs a configurable wait-state read. It assembles 32-bit words from two halfword beats and returns byte/halfword/word data with MIPS sign/zero extension. `busy` drives the pipeline pause request.

---
 rtl/flash_read_ctrl_pkg.sv | 31 +++
 rtl/flash_load_extend.sv | 36 +++
 rtl/flash_read_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_flash_read_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_read_ctrl_pkg.sv
// Shared definitions for the flash read controller.
// Holds the MEM-stage load-op codes used by the pipeline and the controller,
// plus small decode helpers for load validity and alignment.
package flash_read_ctrl_pkg;

   // Load-op codes presented by the MEM stage on req_op.
   localparam logic [2:0] MEM_NOP = 3'd0;
   localparam logic [2:0] MEM_LB  = 3'd1;
   localparam logic [2:0] MEM_LBU = 3'd2;
   localparam logic [2:0] MEM_LH  = 3'd3;
   localparam logic [2:0] MEM_LHU = 3'd4;
   localparam logic [2:0] MEM_LW  = 3'd5;

   // True for codes that require a flash access; everything else is consumed silently.
   function automatic logic is_load(input logic [2:0] op);
      return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
             (op == MEM_LHU) || (op == MEM_LW);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (op == MEM_LW) begin
         bad = (lo != 2'b00);
      end else if ((op == MEM_LH) || (op == MEM_LHU)) begin
         bad = lo[0];
      end
      return bad;
   endfunction

endpackage

// File: rtl/flash_load_extend.sv
// Load data extension for the flash read controller.
// Purely combinational: builds the 32-bit load result from the two flash beats.
// Ports:
//   op    - load-op code (MEM_*)
//   addr0 - byte address bit 0, selects the byte lane for LB/LBU
//   beat0 - first (low) halfword
//   beat1 - second (high) halfword, used by LW only
//   data  - sign/zero extended result
module flash_load_extend
   import flash_read_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic        addr0,
   input  logic [15:0] beat0,
   input  logic [15:0] beat1,
   output logic [31:0] data
);

   logic [7:0] byte_sel;

   // Big lane on odd byte addresses.
   assign byte_sel = addr0 ? beat0[15:8] : beat0[7:0];

   always_comb begin
      data = 32'h0;
      case (op)
         MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
         MEM_LBU: data = {24'h0, byte_sel};
         MEM_LH:  data = {{16{beat0[15]}}, beat0};
         MEM_LHU: data = {16'h0, beat0};
         MEM_LW:  data = {beat1, beat0};
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/flash_read_ctrl.sv
// Read controller for the 16-bit parallel NOR flash behind the MEM stage.
// Accepts one load at a time, writes the read-array command only when the flash
// may have left array mode, performs wait-state reads (two beats for LW) and
// returns extended data with a one-cycle response strobe.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake; req_op load code, req_addr byte address
//   invalidate        - flash left array mode; next access re-issues the command
//   resp_valid        - one-cycle response strobe with resp_data / resp_err
//   busy              - pipeline pause request (controller not idle)
//   flash_*           - flash pins: address, data out/in, data out-enable, strobes
module flash_read_ctrl
   import flash_read_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W         = 23,
   parameter int unsigned WAIT_CYC       = 3,
   parameter int unsigned CMD_SETUP      = 1,
   parameter logic [15:0] READ_ARRAY_CMD = 16'h00FF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic              invalidate,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] flash_addr_o,
   output logic [15:0]       flash_dq_o,
   output logic              flash_dq_oe,
   input  logic [15:0]       flash_dq_i,
   output logic              flash_ce_n,
   output logic              flash_we_n,
   output logic              flash_oe_n
);

   // One shared down-counter covers both the command write and the read waits.
   localparam int unsigned CNT_MAX = (WAIT_CYC > CMD_SETUP) ? WAIT_CYC : CMD_SETUP;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CMD_SETUP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCmdWe,
      StCmdRec,
      StRead,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              array_mode_q, array_mode_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              beat_q, beat_d;
   logic [15:0]       beat0_q, beat0_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rerr_q, rerr_d;

   logic [15:0]       ext_beat0;
   logic [31:0]       ext_data;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W+1];

   // On the final beat of a halfword/byte load the data is still on the bus;
   // for LW the low half was captured on the previous beat.
   assign ext_beat0 = (op_q == MEM_LW) ? beat0_q : flash_dq_i;

   flash_load_extend u_extend (
      .op    (op_q),
      .addr0 (addr_lo_q[0]),
      .beat0 (ext_beat0),
      .beat1 (flash_dq_i),
      .data  (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         array_mode_q <= 1'b0;
         op_q         <= MEM_NOP;
         addr_lo_q    <= 2'b00;
         beat_q       <= 1'b0;
         beat0_q      <= 16'h0;
         faddr_q      <= '0;
         rdata_q      <= 32'h0;
         rerr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         array_mode_q <= array_mode_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         beat_q       <= beat_d;
         beat0_q      <= beat0_d;
         faddr_q      <= faddr_d;
         rdata_q      <= rdata_d;
         rerr_q       <= rerr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      array_mode_d = array_mode_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      beat_d       = beat_q;
      beat0_d      = beat0_q;
      faddr_d      = faddr_q;
      rdata_d      = rdata_q;
      rerr_d       = rerr_q;

      flash_ce_n   = 1'b1;
      flash_we_n   = 1'b1;
      flash_oe_n   = 1'b1;
      flash_dq_oe  = 1'b0;
      flash_dq_o   = 16'h0;

      case (state_q)
         StIdle: begin
            if (req_valid && is_load(req_op)) begin
               op_d      = req_op;
               addr_lo_d = req_addr[1:0];
               beat_d    = 1'b0;
               if (is_misaligned(req_op, req_addr[1:0])) begin
                  // No flash access; flash_addr_o keeps its previous value.
                  rdata_d = 32'h0;
                  rerr_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  faddr_d = req_addr[ADDR_W:1];
                  if (array_mode_q) begin
                     cnt_d   = WAIT_LOAD;
                     state_d = StRead;
                  end else begin
                     cnt_d   = SETUP_LOAD;
                     state_d = StCmdWe;
                  end
               end
            end
         end

         StCmdWe: begin
            flash_ce_n  = 1'b0;
            flash_we_n  = 1'b0;
            flash_dq_oe = 1'b1;
            flash_dq_o  = READ_ARRAY_CMD;
            if (cnt_q == '0) begin
               state_d = StCmdRec;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         StCmdRec: begin
            // we_n rises while data is still driven so the flash latches the command.
            flash_ce_n   = 1'b0;
            flash_dq_oe  = 1'b1;
            flash_dq_o   = READ_ARRAY_CMD;
            array_mode_d = 1'b1;
            cnt_d        = WAIT_LOAD;
            state_d      = StRead;
         end

         StRead: begin
            flash_ce_n = 1'b0;
            flash_oe_n = 1'b0;
            if (cnt_q == '0) begin
               if ((op_q == MEM_LW) && !beat_q) begin
                  beat0_d = flash_dq_i;
                  beat_d  = 1'b1;
                  faddr_d = faddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  cnt_d   = WAIT_LOAD;
               end else begin
                  rdata_d = ext_data;
                  rerr_d  = 1'b0;
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Invalidate overrides the set from the command-recovery cycle.
      if (invalidate) begin
         array_mode_d = 1'b0;
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign resp_valid   = (state_q == StDone);
   assign resp_data    = rdata_q;
   assign resp_err     = rerr_q;
   assign flash_addr_o = faddr_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl: table of load requests with
// hand-computed data/latency, plus sequences for NOP, reset-after-reset and
// reset during a read.
module tb_flash_read_ctrl;
   import flash_read_ctrl_pkg::*;

   localparam int unsigned ADDR_W = 23;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [31:0]       req_addr;
   logic              invalidate;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic              busy;
   logic [ADDR_W-1:0] flash_addr_o;
   logic [15:0]       flash_dq_o;
   logic              flash_dq_oe;
   logic [15:0]       flash_dq_i;
   logic              flash_ce_n;
   logic              flash_we_n;
   logic              flash_oe_n;

   logic [15:0] mem [0:255];

   int checks   = 0;
   int failures = 0;

   flash_read_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .invalidate   (invalidate),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_err     (resp_err),
      .busy         (busy),
      .flash_addr_o (flash_addr_o),
      .flash_dq_o   (flash_dq_o),
      .flash_dq_oe  (flash_dq_oe),
      .flash_dq_i   (flash_dq_i),
      .flash_ce_n   (flash_ce_n),
      .flash_we_n   (flash_we_n),
      .flash_oe_n   (flash_oe_n)
   );

   always #5 clk = ~clk;

   assign flash_dq_i = mem[flash_addr_o[7:0]];

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] addr;
      logic        inval;
      logic [7:0]  pidx;
      logic [15:0] pval;
      logic [31:0] data;
      logic        err;
      int          lat;
      logic        cmd;
      logic [22:0] faddr;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request in the current cycle (cycle 0) and follow it to the response.
   task automatic run_req(input vec_t v);
      int   got;
      logic cmd_seen;
      logic ce_seen;
      logic we1;
      logic [15:0] dq1;
      logic [31:0] rd;
      logic        re;
      got = -1;
      cmd_seen = 1'b0;
      ce_seen = 1'b0;
      we1 = 1'b1;
      dq1 = 16'h0;
      rd = 32'h0;
      re = 1'b0;
      if (v.inval) begin
         invalidate = 1'b1;
         tick();
         invalidate = 1'b0;
      end
      mem[v.pidx] = v.pval;
      chk({v.name, " ready"}, {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_op    = v.op;
      req_addr  = v.addr;
      tick();
      req_valid = 1'b0;
      req_op    = MEM_NOP;
      req_addr  = 32'hDEAD_BEEF;
      for (int c = 1; c <= 30 && got < 0; c++) begin
         if (c == 1) begin
            we1 = flash_we_n;
            dq1 = flash_dq_o;
            if (!v.err) chk({v.name, " flash_addr"}, {9'h0, flash_addr_o}, {9'h0, v.faddr});
         end
         if (!flash_we_n && flash_dq_oe && flash_dq_o == 16'h00FF) cmd_seen = 1'b1;
         if (!flash_ce_n) ce_seen = 1'b1;
         if (resp_valid) begin
            got = c;
            rd  = resp_data;
            re  = resp_err;
         end else begin
            tick();
         end
      end
      chk({v.name, " latency"}, got, v.lat);
      chk({v.name, " data"}, rd, v.data);
      chk({v.name, " err"}, {31'h0, re}, {31'h0, v.err});
      chk({v.name, " cmd_issued"}, {31'h0, cmd_seen}, {31'h0, v.cmd});
      chk({v.name, " ce_active"}, {31'h0, ce_seen}, {31'h0, !v.err});
      if (v.cmd) begin
         chk({v.name, " we_n_c1"}, {31'h0, we1}, 32'h0);
         chk({v.name, " dq_o_c1"}, {16'h0, dq1}, 32'h0000_00FF);
      end
      tick();
      chk({v.name, " strobe_1cyc"}, {30'h0, resp_valid, req_ready}, 32'h1);
      chk({v.name, " data_hold"}, resp_data, v.data);
   endtask

   initial begin
      int no_resp;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[16] = 16'h5678;
      mem[17] = 16'h1234;

      //        name     op       addr          inv pidx  pval      data          err lat cmd faddr
      vecs[0]  = '{"cold_lh",  MEM_LH,  32'h0000_0010, 0, 8'd8, 16'h8001, 32'hFFFF_8001, 0, 6, 1, 23'd8};
      vecs[1]  = '{"warm_lw",  MEM_LW,  32'h0000_0020, 0, 8'd0, 16'h0000, 32'h1234_5678, 0, 7, 0, 23'd16};
      vecs[2]  = '{"lb_hi",    MEM_LB,  32'h0000_0011, 0, 8'd8, 16'h80FE, 32'hFFFF_FF80, 0, 4, 0, 23'd8};
      vecs[3]  = '{"lbu_lo",   MEM_LBU, 32'h0000_0010, 0, 8'd0, 16'h0000, 32'h0000_00FE, 0, 4, 0, 23'd8};
      vecs[4]  = '{"lw_mis",   MEM_LW,  32'h0000_0022, 0, 8'd0, 16'h0000, 32'h0000_0000, 1, 1, 0, 23'd0};
      vecs[5]  = '{"inv_lhu",  MEM_LHU, 32'h0000_0012, 1, 8'd9, 16'h9ABC, 32'h0000_9ABC, 0, 6, 1, 23'd9};
      vecs[6]  = '{"lh_neg",   MEM_LH,  32'h0000_0012, 0, 8'd0, 16'h0000, 32'hFFFF_9ABC, 0, 4, 0, 23'd9};
      vecs[7]  = '{"lh_mis",   MEM_LH,  32'h0000_0013, 0, 8'd0, 16'h0000, 32'h0000_0000, 1, 1, 0, 23'd0};
      vecs[8]  = '{"lbu_hi",   MEM_LBU, 32'h0000_0013, 0, 8'd0, 16'h0000, 32'h0000_009A, 0, 4, 0, 23'd9};
      vecs[9]  = '{"lb_lo",    MEM_LB,  32'h0000_0012, 0, 8'd0, 16'h0000, 32'hFFFF_FFBC, 0, 4, 0, 23'd9};
      vecs[10] = '{"lhu_pos",  MEM_LHU, 32'h0000_0020, 0, 8'd0, 16'h0000, 32'h0000_5678, 0, 4, 0, 23'd16};

      rst = 1'b1;
      req_valid = 1'b0;
      req_op = MEM_NOP;
      req_addr = 32'h0;
      invalidate = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_strobes", {29'h0, flash_ce_n, flash_we_n, flash_oe_n}, 32'h7);
      chk("rst_dq", {15'h0, flash_dq_oe, flash_dq_o}, 32'h0);
      chk("rst_addr", {9'h0, flash_addr_o}, 32'h0);
      chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
      chk("rst_data", resp_data, 32'h0);

      for (int i = 0; i < 11; i++) run_req(vecs[i]);

      // NOP is consumed without a response or any busy cycle.
      req_valid = 1'b1;
      req_op    = MEM_NOP;
      req_addr  = 32'h0000_0010;
      tick();
      req_valid = 1'b0;
      no_resp = 0;
      chk("nop_busy", {31'h0, busy}, 32'h0);
      for (int c = 0; c < 8; c++) begin
         if (resp_valid) no_resp++;
         tick();
      end
      chk("nop_no_resp", no_resp, 0);

      // Reset asserted in cycle 2 of a warm LW.
      req_valid = 1'b1;
      req_op    = MEM_LW;
      req_addr  = 32'h0000_0020;
      tick();
      req_valid = 1'b0;
      tick();
      chk("rstmid_busy_c2", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_strobes", {29'h0, flash_ce_n, flash_we_n, flash_oe_n}, 32'h7);
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
      no_resp = 0;
      for (int c = 0; c < 10; c++) begin
         if (resp_valid) no_resp++;
         tick();
      end
      chk("rstmid_no_resp", no_resp, 0);
      run_req('{"post_rst_lh", MEM_LH, 32'h0000_0010, 0, 8'd0, 16'h0000, 32'hFFFF_80FE, 0, 6, 1, 23'd8});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
